// File: rtl/pipe_stage_skid.sv
// Parametrised pipeline stage register: control + data bundles behind a valid/ready handshake,
// with an optional 2-entry skid buffer, synchronous flush and a saturating stall counter.
module pipe_stage_skid #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 8,
    parameter int SKID   = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cnt
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } state_t;

    state_t            state_reg, state_next;
    logic [CTRL_W-1:0] main_ctrl_reg, main_ctrl_next;
    logic [DATA_W-1:0] main_data_reg, main_data_next;
    logic [CTRL_W-1:0] skid_ctrl_reg, skid_ctrl_next;
    logic [DATA_W-1:0] skid_data_reg, skid_data_next;
    logic [CNT_W-1:0]  stall_cnt_reg, stall_cnt_next;
    logic              in_fire;
    logic              out_fire;

    assign out_valid = (state_reg != ST_EMPTY);
    assign out_fire  = out_valid & out_ready;
    assign in_fire   = in_valid & in_ready;
    assign out_data  = main_data_reg;
    assign stall_cnt = stall_cnt_reg;

    // With the skid buffer, in_ready depends on registered state only, breaking the
    // combinational ready chain; without it, a full stage accepts only when draining.
    generate
        if (SKID != 0) begin : g_skid_ready
            assign in_ready = (state_reg != ST_SKID);
        end else begin : g_reg_ready
            assign in_ready = out_ready | ~out_valid;
        end
    endgenerate

    // Bubbles must never carry live control bits downstream.
    genvar gi;
    generate
        for (gi = 0; gi < CTRL_W; gi++) begin : g_ctrl_gate
            assign out_ctrl[gi] = out_valid & main_ctrl_reg[gi];
        end
    endgenerate

    always_comb begin
        state_next     = state_reg;
        main_ctrl_next = main_ctrl_reg;
        main_data_next = main_data_reg;
        skid_ctrl_next = skid_ctrl_reg;
        skid_data_next = skid_data_reg;
        stall_cnt_next = stall_cnt_reg;

        unique case (state_reg)
            ST_EMPTY: begin
                if (in_fire) begin
                    state_next     = ST_FULL;
                    main_ctrl_next = in_ctrl;
                    main_data_next = in_data;
                end
            end
            ST_FULL: begin
                if (in_fire && out_fire) begin
                    main_ctrl_next = in_ctrl;
                    main_data_next = in_data;
                end else if (in_fire) begin
                    // Only reachable with the skid buffer: the register stage never
                    // accepts while full and stalled.
                    state_next     = ST_SKID;
                    skid_ctrl_next = in_ctrl;
                    skid_data_next = in_data;
                end else if (out_fire) begin
                    state_next = ST_EMPTY;
                end
            end
            ST_SKID: begin
                if (out_fire) begin
                    state_next     = ST_FULL;
                    main_ctrl_next = skid_ctrl_reg;
                    main_data_next = skid_data_reg;
                end
            end
            default: state_next = ST_EMPTY;
        endcase

        // Flush drops every held beat (and any beat accepted this cycle); data is left
        // in place so out_data stays stable, only control is scrubbed.
        if (flush) begin
            state_next     = ST_EMPTY;
            main_ctrl_next = '0;
            skid_ctrl_next = '0;
            main_data_next = main_data_reg;
            skid_data_next = skid_data_reg;
        end

        if (out_valid && !out_ready && (stall_cnt_reg != {CNT_W{1'b1}})) begin
            stall_cnt_next = stall_cnt_reg + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_EMPTY;
            main_ctrl_reg <= '0;
            main_data_reg <= '0;
            skid_ctrl_reg <= '0;
            skid_data_reg <= '0;
            stall_cnt_reg <= '0;
        end else begin
            state_reg     <= state_next;
            main_ctrl_reg <= main_ctrl_next;
            main_data_reg <= main_data_next;
            skid_ctrl_reg <= skid_ctrl_next;
            skid_data_reg <= skid_data_next;
            stall_cnt_reg <= stall_cnt_next;
        end
    end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid: a skid-buffered stage (a_*) and a plain register
// stage with a 4-bit stall counter (b_*), driven by one linear sequence.
module tb_pipe_stage_skid;

    logic        clk;
    logic        rst_n;

    logic        a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [7:0]  a_in_ctrl, a_out_ctrl;
    logic [31:0] a_in_data, a_out_data;
    logic [15:0] a_stall_cnt;

    logic        b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [7:0]  b_in_ctrl, b_out_ctrl;
    logic [31:0] b_in_data, b_out_data;
    logic [3:0]  b_stall_cnt;

    int total;
    int passed;
    int failed;

    pipe_stage_skid #(.DATA_W(32), .CTRL_W(8), .SKID(1), .CNT_W(16)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .flush(a_flush),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_ctrl(a_in_ctrl), .in_data(a_in_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_ctrl(a_out_ctrl),
        .out_data(a_out_data), .stall_cnt(a_stall_cnt)
    );

    pipe_stage_skid #(.DATA_W(32), .CTRL_W(8), .SKID(0), .CNT_W(4)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .flush(b_flush),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_ctrl(b_in_ctrl), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_ctrl(b_out_ctrl),
        .out_data(b_out_data), .stall_cnt(b_stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        total  = 0;
        passed = 0;
        failed = 0;
        rst_n  = 1'b0;
        a_flush = 1'b0; a_in_valid = 1'b0; a_in_ctrl = '0; a_in_data = '0; a_out_ready = 1'b1;
        b_flush = 1'b0; b_in_valid = 1'b0; b_in_ctrl = '0; b_in_data = '0; b_out_ready = 1'b1;

        // Reset values, observed before the first clock edge
        #2;
        chk("rst_out_valid", 64'(a_out_valid), 64'd0);
        chk("rst_out_ctrl",  64'(a_out_ctrl),  64'd0);
        chk("rst_out_data",  64'(a_out_data),  64'd0);
        chk("rst_stall",     64'(a_stall_cnt), 64'd0);
        chk("rst_in_ready",  64'(a_in_ready),  64'd1);
        chk("rst_b_in_ready", 64'(b_in_ready), 64'd1);
        tick();
        tick();
        rst_n = 1'b1;
        #2;

        // 1: streaming, one beat per cycle, one cycle latency
        a_in_valid = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            a_in_data = 32'(i);
            a_in_ctrl = 8'(i);
            tick();
            chk("stream_valid", 64'(a_out_valid), 64'd1);
            chk("stream_data",  64'(a_out_data),  64'(i));
            chk("stream_ctrl",  64'(a_out_ctrl),  64'(i));
        end
        a_in_valid = 1'b0;
        a_in_data  = 'x;
        a_in_ctrl  = 'x;
        tick();
        chk("stream_drain_valid", 64'(a_out_valid), 64'd0);
        chk("stream_drain_ctrl",  64'(a_out_ctrl),  64'd0);
        chk("stream_hold_data",   64'(a_out_data),  64'd8);
        chk("stream_stall",       64'(a_stall_cnt), 64'd0);

        // 2: backpressure fills the skid entry, then drains in order
        a_out_ready = 1'b0;
        a_in_valid  = 1'b1;
        a_in_data = 32'hA1; a_in_ctrl = 8'h11;
        tick();
        chk("bp_a_data",  64'(a_out_data), 64'hA1);
        chk("bp_a_ready", 64'(a_in_ready), 64'd1);
        a_in_data = 32'hB2; a_in_ctrl = 8'h22;
        tick();
        chk("bp_skid_ready", 64'(a_in_ready),  64'd0);
        chk("bp_skid_data",  64'(a_out_data),  64'hA1);
        chk("bp_skid_stall", 64'(a_stall_cnt), 64'd1);
        a_in_data = 32'hC3; a_in_ctrl = 8'h33;
        tick();
        tick();
        chk("bp_hold_data",  64'(a_out_data),  64'hA1);
        chk("bp_hold_ctrl",  64'(a_out_ctrl),  64'h11);
        chk("bp_hold_ready", 64'(a_in_ready),  64'd0);
        chk("bp_hold_stall", 64'(a_stall_cnt), 64'd3);
        a_out_ready = 1'b1;
        tick();
        chk("bp_b_data",  64'(a_out_data),  64'hB2);
        chk("bp_b_ctrl",  64'(a_out_ctrl),  64'h22);
        chk("bp_b_ready", 64'(a_in_ready),  64'd1);
        tick();
        chk("bp_c_data",  64'(a_out_data),  64'hC3);
        chk("bp_c_valid", 64'(a_out_valid), 64'd1);
        a_in_valid = 1'b0;
        tick();
        chk("bp_empty_valid", 64'(a_out_valid), 64'd0);
        chk("bp_final_stall", 64'(a_stall_cnt), 64'd3);

        // 3: flush while in the skid state with all control bits set
        a_out_ready = 1'b0;
        a_in_valid  = 1'b1;
        a_in_data = 32'hD4; a_in_ctrl = 8'hFF;
        tick();
        a_in_data = 32'hE5; a_in_ctrl = 8'hFF;
        tick();
        chk("fl_pre_ready", 64'(a_in_ready), 64'd0);
        chk("fl_pre_ctrl",  64'(a_out_ctrl), 64'hFF);
        a_flush = 1'b1;
        a_in_data = 32'hF6; a_in_ctrl = 8'h77;
        tick();
        chk("fl_valid", 64'(a_out_valid), 64'd0);
        chk("fl_ctrl",  64'(a_out_ctrl),  64'd0);
        chk("fl_ready", 64'(a_in_ready),  64'd1);
        chk("fl_data",  64'(a_out_data),  64'hD4);
        chk("fl_stall", 64'(a_stall_cnt), 64'd5);
        a_flush = 1'b0;
        a_in_valid = 1'b0;
        a_out_ready = 1'b1;
        tick();
        chk("fl_stays_empty", 64'(a_out_valid), 64'd0);
        // a beat accepted in the flush cycle is discarded
        a_flush = 1'b1;
        a_in_valid = 1'b1;
        a_in_data = 32'h99; a_in_ctrl = 8'h09;
        tick();
        chk("fl_fire_valid", 64'(a_out_valid), 64'd0);
        chk("fl_fire_data",  64'(a_out_data),  64'hD4);
        a_flush = 1'b0;
        a_in_data = 32'h55; a_in_ctrl = 8'h05;
        tick();
        chk("fl_after_valid", 64'(a_out_valid), 64'd1);
        chk("fl_after_data",  64'(a_out_data),  64'h55);
        chk("fl_after_ctrl",  64'(a_out_ctrl),  64'h05);
        chk("fl_stall_kept",  64'(a_stall_cnt), 64'd5);
        a_in_valid = 1'b0;
        tick();

        // 5: asynchronous reset while full
        a_out_ready = 1'b0;
        a_in_valid  = 1'b1;
        a_in_data = 32'h66; a_in_ctrl = 8'h3C;
        tick();
        chk("ar_full_valid", 64'(a_out_valid), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_valid", 64'(a_out_valid), 64'd0);
        chk("ar_ctrl",  64'(a_out_ctrl),  64'd0);
        chk("ar_data",  64'(a_out_data),  64'd0);
        chk("ar_stall", 64'(a_stall_cnt), 64'd0);
        chk("ar_ready", 64'(a_in_ready),  64'd1);
        tick();
        rst_n = 1'b1;
        a_out_ready = 1'b1;
        a_in_data = 32'h77; a_in_ctrl = 8'h01;
        #1;
        chk("ar_rel_empty", 64'(a_out_valid), 64'd0);
        tick();
        chk("ar_first_valid", 64'(a_out_valid), 64'd1);
        chk("ar_first_data",  64'(a_out_data),  64'h77);
        a_in_valid = 1'b0;

        // 4: register-only stage, ready follows out_ready combinationally
        b_in_valid = 1'b1;
        b_in_data = 32'h10; b_in_ctrl = 8'h01;
        tick();
        chk("r0_data", 64'(b_out_data), 64'h10);
        b_out_ready = 1'b0;
        b_in_data = 32'h20; b_in_ctrl = 8'h02;
        #1;
        chk("r0_ready_low", 64'(b_in_ready), 64'd0);
        tick();
        chk("r0_hold_data", 64'(b_out_data),  64'h10);
        chk("r0_stall",     64'(b_stall_cnt), 64'd1);
        b_out_ready = 1'b1;
        #1;
        chk("r0_ready_high", 64'(b_in_ready), 64'd1);
        tick();
        chk("r0_repl_data", 64'(b_out_data), 64'h20);
        chk("r0_repl_ctrl", 64'(b_out_ctrl), 64'h02);

        // 6: stall counter saturates and survives flush
        b_in_valid  = 1'b0;
        b_out_ready = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        chk("sat_mid", 64'(b_stall_cnt), 64'd11);
        for (int i = 0; i < 10; i++) tick();
        chk("sat_top", 64'(b_stall_cnt), 64'd15);
        b_flush = 1'b1;
        tick();
        chk("sat_flush_valid", 64'(b_out_valid), 64'd0);
        chk("sat_flush_cnt",   64'(b_stall_cnt), 64'd15);
        b_flush = 1'b0;
        tick();
        chk("sat_after_cnt", 64'(b_stall_cnt), 64'd15);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
